// File: rtl/wishbone_exerciser.sv
// Wishbone master traffic generator: single transfers, write sweeps, read-verify
// sweeps and write-then-verify runs, with progress and error status for display.
module wishbone_exerciser #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_we,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic              wishbone_cyc_o,
  output logic              wishbone_stb_o,
  output logic              wishbone_we_o,
  output logic [ADDR_W-1:0] wishbone_addr_o,
  output logic [DATA_W-1:0] wishbone_data_o,
  output logic [SEL_W-1:0]  wishbone_select_o,
  input  logic [DATA_W-1:0] wishbone_data_i,
  input  logic              wishbone_ack_i,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [ADDR_W-1:0] first_bad_addr,
  output logic [DATA_W-1:0] last_rdata,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic [1:0]        dbg_state
);

  // Handshake: a transfer completes on the rising edge where cyc_o, stb_o and
  // ack_i are all high; ack_i in any other cycle is ignored.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] base_addr_q, base_addr_d;
  logic [DATA_W-1:0] base_data_q, base_data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              pass_q, pass_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  mis_q, mis_d;
  logic [ADDR_W-1:0] fba_q, fba_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  xfer_q, xfer_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;

  logic [DATA_W-1:0] rd_mask;
  logic              miscompare;
  logic              last_word;
  logic [CNT_W-1:0]  idx_nxt;

  always_comb begin
    rd_mask = '0;
    for (int b = 0; b < SEL_W; b++) begin
      rd_mask[b*8 +: 8] = {8{sel_q[b]}};
    end
  end

  assign miscompare = |((wishbone_data_i ^ data_q) & rd_mask);
  assign last_word  = (mode_q == 2'd0) || (idx_q == count_q - CNT_W'(1));
  assign idx_nxt    = idx_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    base_addr_d = base_addr_q;
    base_data_d = base_data_q;
    count_d     = count_q;
    idx_d       = idx_q;
    pass_d      = pass_q;
    wait_d      = wait_q;
    done_d      = done_q;
    err_d       = err_q;
    mis_d       = mis_q;
    fba_d       = fba_q;
    rdata_d     = rdata_q;
    xfer_d      = xfer_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    sel_d       = sel_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d      = mode;
          base_addr_d = cfg_addr;
          base_data_d = cfg_data;
          count_d     = cfg_count;
          idx_d       = '0;
          pass_d      = 1'b0;
          wait_d      = '0;
          done_d      = 1'b0;
          err_d       = 1'b0;
          mis_d       = '0;
          fba_d       = '0;
          xfer_d      = '0;
          addr_d      = cfg_addr;
          data_d      = cfg_data;
          sel_d       = cfg_sel;
          we_d        = (mode == 2'd0) ? cfg_we : (mode != 2'd2);
          if (mode != 2'd0 && cfg_count == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (wishbone_ack_i) begin
          xfer_d = xfer_q + CNT_W'(1);
          if (!we_q) begin
            rdata_d = wishbone_data_i;
            if (mode_q != 2'd0 && miscompare) begin
              if (mis_q == '0) fba_d = addr_q;
              if (mis_q != CNT_MAX) mis_d = mis_q + CNT_W'(1);
            end
          end
          if (!last_word) begin
            idx_d   = idx_nxt;
            addr_d  = base_addr_q + ADDR_W'(idx_nxt);
            data_d  = base_data_q + DATA_W'(idx_nxt);
            state_d = S_GAP;
          end else if (mode_q == 2'd3 && !pass_q) begin
            // Write pass finished: replay the same words as a verify pass.
            pass_d  = 1'b1;
            idx_d   = '0;
            xfer_d  = '0;
            we_d    = 1'b0;
            addr_d  = base_addr_q;
            data_d  = base_data_q;
            state_d = S_GAP;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_GAP: begin
        wait_d  = '0;
        state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      base_addr_q <= '0;
      base_data_q <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      pass_q      <= 1'b0;
      wait_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mis_q       <= '0;
      fba_q       <= '0;
      rdata_q     <= '0;
      xfer_q      <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      sel_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      base_addr_q <= base_addr_d;
      base_data_q <= base_data_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      wait_q      <= wait_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mis_q       <= mis_d;
      fba_q       <= fba_d;
      rdata_q     <= rdata_d;
      xfer_q      <= xfer_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
    end
  end

  assign wishbone_cyc_o    = req_q;
  assign wishbone_stb_o    = req_q;
  assign wishbone_we_o     = we_q;
  assign wishbone_addr_o   = addr_q;
  assign wishbone_data_o   = data_q;
  assign wishbone_select_o = sel_q;
  assign busy              = (state_q == S_REQ) || (state_q == S_GAP);
  assign done              = done_q;
  assign err_timeout       = err_q;
  assign mismatch_cnt      = mis_q;
  assign first_bad_addr    = fba_q;
  assign last_rdata        = rdata_q;
  assign xfer_cnt          = xfer_q;
  assign dbg_state         = state_q;

endmodule
